// File: rtl/pdm_frontend_pkg.sv
// Shared types and the tally-to-PCM conversion used by the PDM microphone front-end.
package pdm_frontend_pkg;

  // Widest supported OUT_W; FIFO entries only keep the low OUT_W bits.
  localparam int unsigned SampleMaxW = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  typedef struct packed {
    channel_e                channel;
    logic [SampleMaxW-1:0]   sample;
  } fifo_entry_t;

  // Centre the ones-count around zero, clamp to log2(decim) signed bits, then
  // rescale to out_w bits. The result is sign-extended into an int.
  function automatic int pcm_convert(int tally, int decim, int out_w);
    int half;
    int l;
    int c;
    half = decim / 2;
    l    = $clog2(decim);
    c    = tally - half;
    if (c > half - 1) begin
      c = half - 1;
    end else if (c < -half) begin
      c = -half;
    end
    if (l > out_w) begin
      c = c >>> (l - out_w);
    end else if (l < out_w) begin
      c = c <<< (out_w - l);
    end
    return c;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO; a push at full is accepted when a pop happens in the same cycle.
module sample_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  // Head reads as zero while empty so the outputs are clean through reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pdm_mic_frontend.sv
// PDM microphone front-end: mic clock generation, per-channel boxcar decimation to signed PCM,
// and a small sample FIFO with overflow counting.
module pdm_mic_frontend
  import pdm_frontend_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 32,
  parameter int unsigned DECIM      = 256,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned STEREO     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable_in,
  input  logic             mic_data_in,
  output logic             mic_clk_out,
  output logic             pdm_tick_out,
  output logic             bit_out,
  output logic [OUT_W-1:0] sample_out,
  output logic             channel_out,
  output logic             sample_valid_out,
  input  logic             sample_ready_in,
  output logic [15:0]      overflow_count_out
);

  localparam int unsigned HalfDiv = CLK_DIV / 2;
  localparam int unsigned DivW    = $clog2(CLK_DIV);
  localparam int unsigned IdxW    = $clog2(DECIM);
  localparam int unsigned TallyW  = IdxW + 1;

  logic [DivW-1:0]   div_q, div_d;
  logic              mic_clk_q, mic_clk_d, tick_q, tick_d, bit_q, bit_d;
  logic [TallyW-1:0] tally_q [2];
  logic [TallyW-1:0] tally_d [2];
  logic [IdxW-1:0]   idx_q [2];
  logic [IdxW-1:0]   idx_d [2];
  logic              done_q, done_d;
  channel_e          done_ch_q, done_ch_d;
  logic [TallyW-1:0] tot_q, tot_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [1:0]        inst;
  fifo_entry_t       push_entry;
  logic              push, pop, fifo_full, fifo_empty;
  logic [OUT_W:0]    fifo_rdata;
  logic              unused_sample_msbs;

  always_comb begin
    div_d     = (div_q == DivW'(CLK_DIV - 1)) ? '0 : div_q + DivW'(1);
    inst[0]   = (div_q == DivW'(HalfDiv - 1));
    inst[1]   = (STEREO != 0) && (div_q == DivW'(CLK_DIV - 1));
    mic_clk_d = (div_q < DivW'(HalfDiv));
    tick_d    = (div_q == '0);
    bit_d     = inst[0] ? mic_data_in : bit_q;
    done_d    = 1'b0;
    done_ch_d = CH_LEFT;
    tot_d     = tot_q;
    for (int ch = 0; ch < 2; ch++) begin
      tally_d[ch] = tally_q[ch];
      idx_d[ch]   = idx_q[ch];
      if (!enable_in) begin
        tally_d[ch] = '0;
        idx_d[ch]   = '0;
      end else if (inst[ch]) begin
        if (idx_q[ch] == IdxW'(DECIM - 1)) begin
          done_d      = 1'b1;
          done_ch_d   = (ch == 0) ? CH_LEFT : CH_RIGHT;
          tot_d       = tally_q[ch] + TallyW'(mic_data_in);
          tally_d[ch] = '0;
          idx_d[ch]   = '0;
        end else begin
          tally_d[ch] = tally_q[ch] + TallyW'(mic_data_in);
          idx_d[ch]   = idx_q[ch] + IdxW'(1);
        end
      end
    end
  end

  // Conversion happens the cycle after the final bit; the FIFO registers it at the end of it.
  always_comb begin
    push_entry.channel = done_ch_q;
    push_entry.sample  = SampleMaxW'(pcm_convert(int'(tot_q), int'(DECIM), int'(OUT_W)));
  end

  assign unused_sample_msbs = ^(push_entry.sample >> OUT_W);

  assign push = done_q && enable_in;
  assign pop  = sample_valid_out && sample_ready_in;

  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_q     <= '0;
      mic_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      bit_q     <= 1'b0;
      tally_q   <= '{default: '0};
      idx_q     <= '{default: '0};
      done_q    <= 1'b0;
      done_ch_q <= CH_LEFT;
      tot_q     <= '0;
      ovf_q     <= '0;
    end else begin
      div_q     <= div_d;
      mic_clk_q <= mic_clk_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      tally_q   <= tally_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      tot_q     <= tot_d;
      ovf_q     <= ovf_d;
    end
  end

  sample_fifo #(
    .Width(OUT_W + 1),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .push_i (push),
    .wdata_i({push_entry.channel, push_entry.sample[OUT_W-1:0]}),
    .pop_i  (sample_ready_in),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign mic_clk_out        = mic_clk_q;
  assign pdm_tick_out       = tick_q;
  assign bit_out            = bit_q;
  assign sample_out         = fifo_rdata[OUT_W-1:0];
  assign channel_out        = fifo_rdata[OUT_W];
  assign sample_valid_out   = !fifo_empty;
  assign overflow_count_out = ovf_q;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Bench for pdm_mic_frontend: a mono and a stereo instance checked every cycle against a
// window-counting reference model with a queue-based FIFO scoreboard.
module tb_pdm_mic_frontend;

  localparam int CD_A  = 8;
  localparam int DEC_A = 256;
  localparam int CD_B  = 4;
  localparam int DEC_B = 64;
  localparam int OW    = 8;
  localparam int DEPTH = 4;

  localparam int M_ONES  = 0;
  localparam int M_ZEROS = 1;
  localparam int M_ALT   = 2;
  localparam int M_LR    = 3;
  localparam int M_RAND  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic [1:0] mic;
  logic [1:0] rdy;
  wire  [1:0] mclk, tick, bitq, valid, chan;
  wire  [7:0] samp_a, samp_b;
  wire  [15:0] ovf_a, ovf_b;

  pdm_mic_frontend #(
    .CLK_DIV(CD_A), .DECIM(DEC_A), .OUT_W(OW), .STEREO(0), .FIFO_DEPTH(DEPTH)
  ) u_mono (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en), .mic_data_in(mic[0]),
    .mic_clk_out(mclk[0]), .pdm_tick_out(tick[0]), .bit_out(bitq[0]),
    .sample_out(samp_a), .channel_out(chan[0]), .sample_valid_out(valid[0]),
    .sample_ready_in(rdy[0]), .overflow_count_out(ovf_a)
  );

  pdm_mic_frontend #(
    .CLK_DIV(CD_B), .DECIM(DEC_B), .OUT_W(OW), .STEREO(1), .FIFO_DEPTH(DEPTH)
  ) u_stereo (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en), .mic_data_in(mic[1]),
    .mic_clk_out(mclk[1]), .pdm_tick_out(tick[1]), .bit_out(bitq[1]),
    .sample_out(samp_b), .channel_out(chan[1]), .sample_valid_out(valid[1]),
    .sample_ready_in(rdy[1]), .overflow_count_out(ovf_b)
  );

  int errors = 0;
  int checks = 0;
  int k;
  int mode [2];
  int ones_m [2][2];
  int cnt_m [2][2];
  logic [8:0] expq [2][$];
  logic [8:0] popped [2][$];
  bit   pend_v [2];
  int   pend_due [2];
  logic [8:0] pend_e [2];
  int   ovf_m [2];
  logic mclk_m [2];
  logic tick_m [2];
  logic bit_m [2];

  function automatic int cd_of(int d);
    return (d == 0) ? CD_A : CD_B;
  endfunction

  function automatic int dec_of(int d);
    return (d == 0) ? DEC_A : DEC_B;
  endfunction

  // Ones in the window, centred, clamped, then scaled to OW bits with floor rounding.
  function automatic int model_pcm(int n1, int dec, int ow);
    int l, c, p;
    l = $clog2(dec);
    c = n1 - dec / 2;
    if (c > dec / 2 - 1) c = dec / 2 - 1;
    if (l > ow) begin
      p = 1 << (l - ow);
      c = (c >= 0) ? c / p : -((-c + p - 1) / p);
    end else begin
      c = c * (1 << (ow - l));
    end
    return c;
  endfunction

  function automatic logic drive_bit(int d, int m, int kk);
    int cd;
    cd = cd_of(d);
    case (m)
      M_ONES:  return 1'b1;
      M_ZEROS: return 1'b0;
      M_ALT:   return ((kk / cd) % 2) == 0;
      M_LR:    return (kk % cd) < cd / 2;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  function automatic logic [28:0] obs_vec(int d, bit mask);
    logic [8:0]  head;
    logic [15:0] o;
    head = (d == 0) ? {chan[0], samp_a} : {chan[1], samp_b};
    o    = (d == 0) ? ovf_a : ovf_b;
    if (mask) head = '0;
    return {mclk[d], tick[d], bitq[d], valid[d], head, o};
  endfunction

  task automatic reset_model();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        ones_m[d][c] = 0;
        cnt_m[d][c]  = 0;
      end
      expq[d].delete();
      pend_v[d] = 1'b0;
      ovf_m[d]  = 0;
      mclk_m[d] = 1'b0;
      tick_m[d] = 1'b0;
      bit_m[d]  = 1'b0;
    end
  endtask

  // One clock cycle: drive data, compare every output, advance the model, cross the edge.
  task automatic step();
    logic [28:0] obs, expv;
    logic [8:0]  eh;
    logic [7:0]  v8;
    bit ev, pop, inst;
    int cd, div, pcm;
    for (int d = 0; d < 2; d++) mic[d] = drive_bit(d, mode[d], k);
    for (int d = 0; d < 2; d++) begin
      cd   = cd_of(d);
      div  = k % cd;
      ev   = expq[d].size() != 0;
      eh   = ev ? expq[d][0] : 9'h000;
      obs  = obs_vec(d, !ev);
      expv = {mclk_m[d], tick_m[d], bit_m[d], ev, eh, ovf_m[d][15:0]};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL cycle dut%0d k=%0d got=%h want=%h", d, k, obs, expv);
      end
      if (valid[d] && rdy[d]) popped[d].push_back((d == 0) ? {chan[0], samp_a} : {chan[1], samp_b});
      pop = ev && rdy[d];
      if (pop) void'(expq[d].pop_front());
      if (pend_v[d] && pend_due[d] == k) begin
        pend_v[d] = 1'b0;
        if (en) begin
          if (expq[d].size() == DEPTH) begin
            if (ovf_m[d] < 65535) ovf_m[d]++;
          end else begin
            expq[d].push_back(pend_e[d]);
          end
        end
      end
      if (div == cd / 2 - 1) bit_m[d] = mic[d];
      for (int c = 0; c < 2; c++) begin
        inst = (c == 0) ? (div == cd / 2 - 1) : (d == 1 && div == cd - 1);
        if (!en) begin
          ones_m[d][c] = 0;
          cnt_m[d][c]  = 0;
        end else if (inst) begin
          ones_m[d][c] += int'(mic[d]);
          cnt_m[d][c]++;
          if (cnt_m[d][c] == dec_of(d)) begin
            pcm = model_pcm(ones_m[d][c], dec_of(d), OW);
            v8  = pcm[7:0];
            pend_v[d]    = 1'b1;
            pend_due[d]  = k + 1;
            pend_e[d]    = {(c == 1), v8};
            ones_m[d][c] = 0;
            cnt_m[d][c]  = 0;
          end
        end
      end
      mclk_m[d] = div < cd / 2;
      tick_m[d] = div == 0;
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check_all_zero(string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec(d, 1'b0) !== 29'h0) begin
        errors++;
        $display("FAIL %s dut%0d got=%h want=0", name, d, obs_vec(d, 1'b0));
      end
    end
  endtask

  task automatic restart_windows();
    en = 1'b0;
    step();
    en = 1'b1;
  endtask

  task automatic test_reset();
    int hi, ti;
    rst_n = 1'b0; en = 1'b0; mic = '0; rdy = '0;
    mode[0] = M_ZEROS; mode[1] = M_ZEROS;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    reset_model();
    hi = 0; ti = 0;
    for (int i = 0; i < 2 * CD_A; i++) begin
      hi += int'(mclk[0]);
      ti += int'(tick[0]);
      step();
    end
    checks++;
    if (hi != CD_A) begin errors++; $display("FAIL mic_clk_high got=%0d want=%0d", hi, CD_A); end
    checks++;
    if (ti != 2) begin errors++; $display("FAIL tick_count got=%0d want=2", ti); end
  endtask

  task automatic test_mono_ones();
    int first_k, second_k, k_en, ks, s;
    bit prev;
    mode[0] = M_ONES; mode[1] = M_RAND; rdy = 2'b11;
    popped[0].delete();
    en = 1'b1;
    k_en = k;
    first_k = -1; second_k = -1; prev = 1'b0;
    for (int i = 0; i < 2 * DEC_A * CD_A + 4 * CD_A; i++) begin
      if (valid[0] && !prev) begin
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
      prev = valid[0];
      step();
    end
    ks = k_en + ((CD_A / 2 - 1 - k_en % CD_A) + CD_A) % CD_A;
    s  = ks + (DEC_A - 1) * CD_A;
    checks++;
    if (first_k != s + 2) begin errors++; $display("FAIL first_valid_cycle got=%0d want=%0d", first_k, s + 2); end
    checks++;
    if (second_k - first_k != DEC_A * CD_A) begin
      errors++; $display("FAIL sample_period got=%0d want=%0d", second_k - first_k, DEC_A * CD_A);
    end
    checks++;
    if (popped[0].size() < 1 || popped[0][0] !== 9'h07F) begin
      errors++; $display("FAIL mono_ones got=%h want=07f", (popped[0].size() > 0) ? popped[0][0] : 9'h1FF);
    end
  endtask

  task automatic test_mono_patterns();
    int pats [2];
    logic [8:0] want [2];
    pats[0] = M_ALT;   want[0] = 9'h000;
    pats[1] = M_ZEROS; want[1] = 9'h080;
    for (int p = 0; p < 2; p++) begin
      mode[0] = pats[p];
      restart_windows();
      popped[0].delete();
      for (int i = 0; i < DEC_A * CD_A + 3 * CD_A; i++) step();
      checks++;
      if (popped[0].size() != 1 || popped[0][0] !== want[p]) begin
        errors++;
        $display("FAIL mono_pattern%0d got=%h n=%0d want=%h", p,
                 (popped[0].size() > 0) ? popped[0][0] : 9'h1FF, popped[0].size(), want[p]);
      end
    end
  endtask

  task automatic test_stereo();
    logic [8:0] want [4];
    want[0] = 9'h07C; want[1] = 9'h180; want[2] = 9'h07C; want[3] = 9'h180;
    mode[0] = M_ONES; mode[1] = M_LR;
    en = 1'b0;
    step();
    while (k % CD_B != 0) step();
    en = 1'b1;
    popped[1].delete();
    for (int i = 0; i < 2 * DEC_B * CD_B + 3 * CD_B; i++) step();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (popped[1].size() <= j || popped[1][j] !== want[j]) begin
        errors++;
        $display("FAIL stereo_order%0d got=%h want=%h", j,
                 (popped[1].size() > j) ? popped[1][j] : 9'h1FF, want[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    mode[0] = M_RAND; mode[1] = M_RAND;
    rdy[0] = 1'b0;
    restart_windows();
    for (int i = 0; i < 6 * DEC_A * CD_A + 2 * CD_A; i++) step();
    checks++;
    if (ovf_a !== 16'd2) begin errors++; $display("FAIL overflow_count got=%0d want=2", ovf_a); end
    rdy[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      n += int'(valid[0] && rdy[0]);
      step();
    end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL drain_count got=%0d want=%0d", n, DEPTH); end
  endtask

  task automatic test_mid_reset();
    int budget;
    mode[0] = M_ONES; rdy = 2'b11;
    restart_windows();
    budget = 0;
    while (cnt_m[0][0] != 100 && budget < DEC_A * CD_A) begin
      step();
      budget++;
    end
    checks++;
    if (cnt_m[0][0] != 100) begin errors++; $display("FAIL reach_bit100 got=%0d want=100", cnt_m[0][0]); end
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_outputs");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    popped[0].delete();
    for (int i = 0; i < DEC_A * CD_A + 3 * CD_A; i++) step();
    checks++;
    if (popped[0].size() != 1 || popped[0][0] !== 9'h07F) begin
      errors++;
      $display("FAIL post_reset_sample got=%h n=%0d want=07f",
               (popped[0].size() > 0) ? popped[0][0] : 9'h1FF, popped[0].size());
    end
  endtask

  initial begin
    test_reset();
    test_mono_ones();
    test_mono_patterns();
    test_stereo();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
